// File: rtl/ram_arbiter_pkg.sv
// Shared bus header for the data-RAM arbiter: master ids and bus widths.
package ram_arbiter_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_BSEL_W = BUS_DATA_W / 8;

    typedef enum logic {
        ARB_ID_I = 1'b0,
        ARB_ID_D = 1'b1
    } arb_id_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Grant picker for the data-RAM arbiter: d over i, with an optional fetch
// starvation guard when RAM_ARB_STARVE_EN is defined.
module ram_arb_pick
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    output logic [1:0] gnt
);

`ifdef RAM_ARB_STARVE_EN
    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Counts consecutive cycles fetch waited; saturates at STARVE_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else if (!i_req || gnt[ARB_ID_I]) begin
            starve_cnt_q <= '0;
        end else if (!starved) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end
`else
    logic starved;
    logic unused_clk_rst;

    assign starved        = 1'b0;
    assign unused_clk_rst = clk ^ rst;
`endif

    always_comb begin
        gnt = '0;
        if (i_req && (!d_req || starved)) begin
            gnt[ARB_ID_I] = 1'b1;
        end else if (d_req) begin
            gnt[ARB_ID_D] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of the single-ported data RAM: grant in T, RAM
// cycle in T+1, response in T+2. Optional fetch anti-starvation: RAM_ARB_STARVE_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = BUS_ADDR_W,
    parameter int unsigned DATA_W     = BUS_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_write_en,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_write_data,
    input  logic [DATA_W-1:0]   ram_read_data
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [1:0] pick;

    ram_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk   (clk),
        .rst   (rst),
        .i_req (i_req),
        .d_req (d_req),
        .gnt   (pick)
    );

    // Grants are forced low while reset is asserted so every output reads 0.
    assign i_gnt = pick[ARB_ID_I] & rst;
    assign d_gnt = pick[ARB_ID_D] & rst;

    logic              cmd_valid_q;
    arb_id_e           cmd_id_q;
    logic [BE_W-1:0]   cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= ARB_ID_I;
            cmd_we_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            cmd_valid_q <= i_gnt | d_gnt;
            if (d_gnt) begin
                cmd_id_q    <= ARB_ID_D;
                cmd_we_q    <= d_we;
                cmd_addr_q  <= d_addr;
                cmd_wdata_q <= d_wdata;
            end else if (i_gnt) begin
                cmd_id_q    <= ARB_ID_I;
                cmd_we_q    <= '0;
                cmd_addr_q  <= i_addr;
                cmd_wdata_q <= '0;
            end
        end
    end

    assign ram_en         = cmd_valid_q;
    assign ram_write_en   = cmd_valid_q ? cmd_we_q    : '0;
    assign ram_addr       = cmd_valid_q ? cmd_addr_q  : '0;
    assign ram_write_data = cmd_valid_q ? cmd_wdata_q : '0;

    logic              resp_valid_q;
    arb_id_e           resp_id_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Per-master data registers hold until that master's next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= ARB_ID_I;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            resp_valid_q <= cmd_valid_q;
            resp_id_q    <= cmd_id_q;
            if (cmd_valid_q && (cmd_id_q == ARB_ID_I)) begin
                i_rdata_q <= ram_read_data;
            end
            if (cmd_valid_q && (cmd_id_q == ARB_ID_D)) begin
                d_rdata_q <= (cmd_we_q == '0) ? ram_read_data : '0;
            end
        end
    end

    assign i_rvalid = resp_valid_q && (resp_id_q == ARB_ID_I);
    assign d_rvalid = resp_valid_q && (resp_id_q == ARB_ID_D);
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
